control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/step_counter.sv | 20 ++
 rtl/control_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and the control-word layout for the CPU control sequencer.
package cpu_pkg;

  localparam int unsigned STEP_W = 3;
  localparam int unsigned OP_W   = 4;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  // One bit per control line, in the order the top drives its ports.
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic bi;
    logic oi;
    logic alu_enable;
    logic alu_sub;
    logic fi;
    logic ce;
    logic co;
    logic j;
  } ctrl_t;

endpackage

// File: rtl/step_counter.sv
// Micro-step counter T0..T4 with a hold input used while halted.
module step_counter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  output logic [STEP_W-1:0] step
);

  // Advance one step per clock, wrapping T4 -> T0; hold when frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= T0;
    end else if (!freeze) begin
      step <= (step == T4) ? T0 : step + STEP_W'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: step counter plus combinational control decode.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic              hlt,
  output logic              mi,
  output logic              ri,
  output logic              ro,
  output logic              ii,
  output logic              io,
  output logic              ai,
  output logic              ao,
  output logic              bi,
  output logic              oi,
  output logic              alu_enable,
  output logic              alu_sub,
  output logic              fi,
  output logic              ce,
  output logic              co,
  output logic              j,
  output logic [STEP_W-1:0] step
);

  logic [STEP_W-1:0] step_q;
  logic              halted;
  logic              halt_now;
  ctrl_t             ctrl;

  // HLT in T2 freezes the counter on the same edge that sets halted.
  assign halt_now = (step_q == T2) && (opcode == OP_HLT);

  step_counter u_step_counter (
    .clk    (clk),
    .rst    (rst),
    .freeze (halted | halt_now),
    .step   (step_q)
  );

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (halt_now) begin
      halted <= 1'b1;
    end
  end

  // Control-word decode from step, opcode and flags.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (halted) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl.co = 1'b1;
          ctrl.mi = 1'b1;
        end
        T1: begin
          ctrl.ro = 1'b1;
          ctrl.ii = 1'b1;
          ctrl.ce = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.io = 1'b1;
              ctrl.mi = 1'b1;
            end
            OP_LDI: begin
              ctrl.io = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_JMP: begin
              ctrl.io = 1'b1;
              ctrl.j  = 1'b1;
            end
            OP_JC: begin
              ctrl.io = carry_flag;
              ctrl.j  = carry_flag;
            end
            OP_JZ: begin
              ctrl.io = zero_flag;
              ctrl.j  = zero_flag;
            end
            OP_OUT: begin
              ctrl.ao = 1'b1;
              ctrl.oi = 1'b1;
            end
            OP_HLT: ctrl.hlt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ro = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ro = 1'b1;
              ctrl.bi = 1'b1;
            end
            OP_STA: begin
              ctrl.ao = 1'b1;
              ctrl.ri = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_enable = 1'b1;
            ctrl.alu_sub    = (opcode == OP_SUB);
            ctrl.ai         = 1'b1;
            ctrl.fi         = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {hlt, mi, ri, ro, ii, io, ai, ao, bi, oi,
          alu_enable, alu_sub, fi, ce, co, j} = ctrl;

  assign step = rst ? T0 : step_q;

endmodule
